// File: rtl/systolic_out_quantizer.sv
// Output quantizer behind the systolic accumulator: round-shift, ReLU and
// saturate each lane, then queue rows for the output-store path.
module systolic_out_quantizer #(
    parameter int ARRAY_M        = 8,
    parameter int ACC_WIDTH      = 48,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int SHIFT_WIDTH    = 6,
    parameter int BEAT_CNT_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [BEAT_CNT_WIDTH-1:0]          cfg_num_beats,
    input  logic [SHIFT_WIDTH-1:0]             cfg_shift,
    input  logic                               cfg_relu,
    output logic                               busy,
    output logic                               done,
    output logic [15:0]                        sat_count,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ARRAY_M*ACC_WIDTH-1:0]       in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ARRAY_M*OUT_DATA_WIDTH-1:0]  out_data
);

    localparam int AW  = ACC_WIDTH;
    localparam int OW  = OUT_DATA_WIDTH;
    localparam int SW  = SHIFT_WIDTH;
    localparam int BW  = BEAT_CNT_WIDTH;
    localparam int RW  = ARRAY_M * OW;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int PCW = $clog2(ARRAY_M + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [AW:0] OMAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] OMIN = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] num_q, num_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          relu_q, relu_d;
    logic [15:0]   sat_q, sat_d;
    logic          clr_sat;

    logic                 v1_q;
    logic signed [AW:0]   r1_q [ARRAY_M];
    logic                 v2_q;
    logic [RW-1:0]        q2_q, q2_d;
    logic [ARRAY_M-1:0]   s2_q, s2_d;

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q;
    logic [PW+1:0] occ;
    logic          accept, fifo_rd;

    // Round-half-up arithmetic shift in one extra bit so the +half never wraps.
    function automatic logic signed [AW:0] rshift(
        input logic signed [AW-1:0] x,
        input logic [SW-1:0]        s
    );
        logic signed [AW:0] xe;
        logic signed [AW:0] rnd;
        logic [SW-1:0]      se;
        se = (int'(s) >= AW) ? SW'(AW - 1) : s;
        xe = {x[AW-1], x};
        if (se == '0) begin
            return xe;
        end
        rnd = (AW+1)'(1) << (se - SW'(1));
        return (xe + rnd) >>> se;
    endfunction

    assign accept    = in_valid && in_ready;
    assign out_valid = (cnt_q != '0);
    assign fifo_rd   = out_valid && out_ready;
    assign out_data  = mem_q[rp_q];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sat_count = sat_q;

    // Admission counts rows still in the pipe so stage 2 always finds a slot.
    assign occ = (PW+2)'(cnt_q) + (PW+2)'(v1_q) + (PW+2)'(v2_q);
    assign in_ready = (state_q == S_RUN) && (beat_q != num_q)
                   && (occ < (PW+2)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        beat_d  = beat_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        clr_sat = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr_sat = 1'b1;
                    if (cfg_num_beats != '0) begin
                        num_d   = cfg_num_beats;
                        shift_d = cfg_shift;
                        relu_d  = cfg_relu;
                        beat_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_d == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!v1_q && !v2_q && cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic [PCW-1:0] pop;
        logic [16:0]    sum;
        pop = '0;
        for (int i = 0; i < ARRAY_M; i++) begin
            pop = pop + PCW'(s2_q[i]);
        end
        sum   = {1'b0, sat_q} + 17'(pop);
        sat_d = sat_q;
        if (clr_sat) begin
            sat_d = '0;
        end else if (v2_q) begin
            sat_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    // ReLU zeroing happens before the clamp and never counts as saturation.
    always_comb begin
        logic signed [AW:0] r;
        q2_d = '0;
        s2_d = '0;
        for (int i = 0; i < ARRAY_M; i++) begin
            r = r1_q[i];
            if (relu_q && r[AW]) begin
                r = '0;
            end
            if (r > OMAX) begin
                r       = OMAX;
                s2_d[i] = 1'b1;
            end else if (r < OMIN) begin
                r       = OMIN;
                s2_d[i] = 1'b1;
            end
            q2_d[i*OW +: OW] = r[OW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            beat_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            beat_q  <= beat_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            q2_q <= '0;
            s2_q <= '0;
            for (int i = 0; i < ARRAY_M; i++) begin
                r1_q[i] <= '0;
            end
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            if (accept) begin
                for (int i = 0; i < ARRAY_M; i++) begin
                    r1_q[i] <= rshift(in_data[i*AW +: AW], shift_q);
                end
            end
            if (v1_q) begin
                q2_q <= q2_d;
                s2_q <= s2_d;
            end else begin
                s2_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (v2_q) begin
                mem_q[wp_q] <= q2_q;
                wp_q        <= wp_q + PW'(1);
            end
            if (fifo_rd) begin
                rp_q <= rp_q + PW'(1);
            end
            if (v2_q && !fifo_rd) begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end else if (!v2_q && fifo_rd) begin
                cnt_q <= cnt_q - (PW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_systolic_out_quantizer.sv
// Scoreboard bench for systolic_out_quantizer: a lane model predicts each
// accepted row, and the output monitor pops and compares in order.
module tb_systolic_out_quantizer;

    localparam int M  = 8;
    localparam int AW = 48;
    localparam int OW = 16;
    localparam int SW = 6;
    localparam int BW = 16;
    localparam int IW = M * AW;
    localparam int QW = M * OW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] cfg_num_beats = '0;
    logic [SW-1:0] cfg_shift = '0;
    logic          cfg_relu = 1'b0;
    logic          busy, done;
    logic [15:0]   sat_count;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [QW-1:0] out_data;

    systolic_out_quantizer dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_num_beats(cfg_num_beats), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .busy(busy), .done(done),
        .sat_count(sat_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [IW-1:0] stim [$];
    logic [QW-1:0] exp_q [$];
    int cur_shift, exp_sat;
    bit cur_relu;
    int acc_cnt, acc_first, acc_last;
    int out_cnt, out_first, out_last;
    int done_cnt = 0;
    int dc, d0, oc;
    bit got;
    bit stall_q = 1'b0;
    logic [QW-1:0] hold_d;
    logic [QW-1:0] last_out = '0;

    task automatic chk(input string tag, input logic [QW-1:0] obs,
                       input logic [QW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [QW-1:0] model(input logic [IW-1:0] d,
        input int s, input bit rl, output int nsat);
        logic [QW-1:0] o;
        longint x, r, one;
        int se;
        o = '0;
        nsat = 0;
        one = 1;
        se = (s >= AW) ? AW - 1 : s;
        for (int i = 0; i < M; i++) begin
            x = longint'($signed(d[i*AW +: AW]));
            r = (se == 0) ? x : ((x + (one << (se - 1))) >>> se);
            if (rl && r < 0) r = 0;
            if (r > 32767) begin
                r = 32767;
                nsat++;
            end else if (r < -32768) begin
                r = -32768;
                nsat++;
            end
            o[i*OW +: OW] = OW'(r);
        end
        return o;
    endfunction

    function automatic logic [IW-1:0] mk(input longint v [M]);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) r[i*AW +: AW] = AW'(v[i]);
        return r;
    endfunction

    function automatic logic [IW-1:0] rnd_row();
        logic [IW-1:0] r;
        longint v;
        for (int i = 0; i < M; i++) begin
            v = longint'({$urandom(), $urandom()}) >>> $urandom_range(16, 47);
            r[i*AW +: AW] = AW'(v);
        end
        return r;
    endfunction

    function automatic int lanev(input logic [QW-1:0] v, input int i);
        return int'($signed(v[i*OW +: OW]));
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_row", QW'(out_valid), '0);
            else chk("row", out_data, exp_q.pop_front());
            last_out = out_data;
            if (out_cnt == 0) out_first = cyc;
            out_last = cyc;
            out_cnt++;
        end
        if (out_valid && !out_ready && stall_q) chk("hold", out_data, hold_d);
        stall_q = out_valid && !out_ready;
        hold_d  = out_data;
    end

    task automatic start_tile(input int nb, input int sh, input bit rl);
        @(posedge clk);
        #1;
        cfg_num_beats = BW'(nb);
        cfg_shift = SW'(sh);
        cfg_relu = rl;
        start = 1'b1;
        cur_shift = sh;
        cur_relu = rl;
        exp_sat = 0;
        acc_cnt = 0;
        out_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed();
        int guard;
        guard = 0;
        while (stim.size() > 0 && guard < 2000) begin
            in_data = stim[0];
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                int ns;
                exp_q.push_back(model(stim[0], cur_shift, cur_relu, ns));
                exp_sat += ns;
                void'(stim.pop_front());
                if (acc_cnt == 0) acc_first = cyc;
                acc_last = cyc;
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_drained", QW'(stim.size()), '0);
        stim.delete();
    endtask

    task automatic wait_done(output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        chk("done_seen", QW'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=0 want=1");
        $fatal(1);
    end

    initial begin
        int er [6];
        er = '{2, 1, -1, -2, 1, 0};
        repeat (3) @(negedge clk);
        chk("rst_busy", QW'(busy), 0);
        chk("rst_done", QW'(done), 0);
        chk("rst_sat", QW'(sat_count), 0);
        chk("rst_in_ready", QW'(in_ready), 0);
        chk("rst_out_valid", QW'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        out_ready = 1'b1;
        start_tile(1, 0, 0);
        stim.push_back(mk('{100, 0, 0, 0, 0, 0, 0, -5}));
        feed();
        got = 1'b0;
        oc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                oc = cyc;
            end
        end
        chk("pt_latency", QW'(oc - acc_last), 3);
        wait_done(dc);
        chk("pt_done_gap", QW'(dc - out_last), 2);
        chk("pt_lane0", QW'(lanev(last_out, 0)), 100);
        chk("pt_lane7", QW'(lanev(last_out, 7)), -5);
        chk("pt_sat", QW'(sat_count), 0);

        start_tile(1, 4, 0);
        stim.push_back(mk('{24, 23, -24, -25, 8, -8, 0, 0}));
        feed();
        wait_done(dc);
        for (int i = 0; i < 6; i++) chk("round_lane", QW'(lanev(last_out, i)), QW'(er[i]));
        chk("round_sat", QW'(sat_count), 0);

        start_tile(1, 0, 0);
        stim.push_back(mk('{40000, -40000, 0, 0, 0, 0, 0, 0}));
        feed();
        wait_done(dc);
        chk("sat_lane0", QW'(lanev(last_out, 0)), 32767);
        chk("sat_lane1", QW'(lanev(last_out, 1)), -32768);
        chk("sat_count2", QW'(sat_count), 2);

        start_tile(1, 0, 1);
        stim.push_back(mk('{40000, -40000, 0, 0, 0, 0, 0, 0}));
        feed();
        wait_done(dc);
        chk("relu_lane0", QW'(lanev(last_out, 0)), 32767);
        chk("relu_lane1", QW'(lanev(last_out, 1)), 0);
        chk("relu_sat1", QW'(sat_count), 1);

        start_tile(8, 55, 0);
        for (int i = 0; i < 8; i++) stim.push_back(rnd_row());
        feed();
        wait_done(dc);
        chk("bigshift_sat", QW'(sat_count), QW'(exp_sat));

        start_tile(8, 20, 1);
        for (int i = 0; i < 8; i++) stim.push_back(rnd_row());
        feed();
        wait_done(dc);
        chk("relu_rand_sat", QW'(sat_count), QW'(exp_sat));

        out_ready = 1'b0;
        start_tile(10, 3, 0);
        for (int i = 0; i < 10; i++) stim.push_back(rnd_row());
        d0 = done_cnt;
        fork
            feed();
            begin
                repeat (15) @(negedge clk);
                chk("bp_accepted", QW'(acc_cnt), 4);
                chk("bp_in_ready", QW'(in_ready), 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_done(dc);
        repeat (5) @(negedge clk);
        chk("bp_done_once", QW'(done_cnt - d0), 1);
        chk("bp_rows", QW'(out_cnt), 10);
        chk("bp_sat", QW'(sat_count), QW'(exp_sat));

        out_ready = 1'b1;
        start_tile(64, 8, 0);
        for (int i = 0; i < 64; i++) stim.push_back(rnd_row());
        d0 = done_cnt;
        fork
            feed();
            begin
                repeat (20) @(posedge clk);
                #1;
                cfg_num_beats = '0;
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        chk("st_accepts", QW'(acc_cnt), 64);
        chk("st_in_gap", QW'(acc_last - acc_first), 63);
        wait_done(dc);
        chk("st_rows", QW'(out_cnt), 64);
        chk("st_out_gap", QW'(out_last - out_first), 63);
        chk("st_done_gap", QW'(dc - out_last), 2);
        repeat (5) @(negedge clk);
        chk("st_done_once", QW'(done_cnt - d0), 1);
        chk("st_sat", QW'(sat_count), QW'(exp_sat));

        out_ready = 1'b0;
        start_tile(10, 0, 0);
        stim.push_back(rnd_row());
        stim.push_back(rnd_row());
        feed();
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", QW'(out_valid), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", QW'(out_valid), 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_busy", QW'(busy), 0);
        chk("mid_rst_ready", QW'(in_ready), 0);
        d0 = done_cnt;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", QW'(done_cnt - d0), 0);
        chk("mid_rst_sat", QW'(sat_count), 0);

        start_tile(0, 0, 0);
        @(negedge clk);
        chk("zero_busy", QW'(busy), 1);
        chk("zero_done", QW'(done), 1);
        chk("zero_valid", QW'(out_valid), 0);
        @(negedge clk);
        chk("zero_busy_end", QW'(busy), 0);
        chk("zero_done_end", QW'(done), 0);
        chk("sb_empty", QW'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
